vga_timing_gen: RTL

- Self-contained, parametrised VGA/SVGA timing generator. Owns both the horizontal and vertical counters and produces registered sync, blank and position outputs.
- Generalised over the earlier generator, which took an external x count and had fixed polarity:
  - per-axis sync polarity,
  - a pixel-enable input for clock-divided pixel rates,
  - a frame counter,
  - an optional programmable line-match strobe.
- Sits between the clock/reset domain root and the pixel/pattern generators; feeds the output pad register stage.

---
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/SVGA timing generator.
// Owns the horizontal/vertical counters and a frame counter, and drives
// registered sync, blank and position outputs one clock behind the counters.
// pix_en gates counter advance so divided pixel rates can share a fast clock.
// Optional build macro: VGA_TIMING_LINE_MATCH_EN adds match_line/line_match,
// a registered pulse one clock after next_row on a programmable line.
module vga_timing_gen #(
    parameter int unsigned WIDTH  = 800,
    parameter int unsigned HEIGHT = 600,
    parameter int unsigned HFRONT = 24,
    parameter int unsigned HSYNC  = 72,
    parameter int unsigned HBACK  = 128,
    parameter int unsigned VFRONT = 1,
    parameter int unsigned VSYNC  = 2,
    parameter int unsigned VBACK  = 22,
    parameter logic        HPOL   = 1'b1,
    parameter logic        VPOL   = 1'b1,
    parameter int unsigned CW     = 11,
    parameter int unsigned FCW    = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    output logic           hsync,
    output logic           vsync,
    output logic           blank,
    output logic           hblank,
    output logic [CW-1:0]  x_pos,
    output logic [CW-1:0]  y_pos,
    output logic           next_row,
    output logic           next_frame,
    output logic [FCW-1:0] frame_count
`ifdef VGA_TIMING_LINE_MATCH_EN
    ,
    input  logic [CW-1:0]  match_line,
    output logic           line_match
`endif
);

    localparam int unsigned HTOTAL = WIDTH + HFRONT + HSYNC + HBACK;
    localparam int unsigned VTOTAL = HEIGHT + VFRONT + VSYNC + VBACK;

    // Counter widths must hold every count value of both axes.
    if (((64'd1 << CW) < 64'(HTOTAL)) || ((64'd1 << CW) < 64'(VTOTAL))) begin : g_cw_check
        $error("vga_timing_gen: CW too small for HTOTAL/VTOTAL");
    end

    // Decode boundaries, pre-sized to the counter width.
    localparam logic [CW-1:0] H_ACT_END = CW'(WIDTH);
    localparam logic [CW-1:0] H_ROW_END = CW'(WIDTH - 1);
    localparam logic [CW-1:0] HS_START  = CW'(WIDTH + HFRONT);
    localparam logic [CW-1:0] HS_END    = CW'(WIDTH + HFRONT + HSYNC);
    localparam logic [CW-1:0] H_LAST    = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END = CW'(HEIGHT);
    localparam logic [CW-1:0] VS_START  = CW'(HEIGHT + VFRONT);
    localparam logic [CW-1:0] VS_END    = CW'(HEIGHT + VFRONT + VSYNC);
    localparam logic [CW-1:0] V_LAST    = CW'(VTOTAL - 1);

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_act;
    logic          vs_act;
    logic          hb;
    logic          vb;

    // Wrap conditions shared by the counters and the strobes.
    always_comb begin
        h_wrap = (h == H_LAST);
        v_wrap = (v == V_LAST);
    end

    // Horizontal/vertical/frame counters, advanced only on pix_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h           <= '0;
            v           <= '0;
            frame_count <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h <= '0;
                if (v_wrap) begin
                    v           <= '0;
                    frame_count <= frame_count + FCW'(1);
                end else begin
                    v <= v + CW'(1);
                end
            end else begin
                h <= h + CW'(1);
            end
        end
    end

    // Sync and blank regions decoded from the current counters.
    always_comb begin
        hs_act = (h >= HS_START) && (h < HS_END);
        vs_act = (v >= VS_START) && (v < VS_END);
        hb     = (h >= H_ACT_END);
        vb     = (v >= V_ACT_END);
    end

    // Output register: updates every clock so it tracks held counters too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync  <= ~HPOL;
            vsync  <= ~VPOL;
            blank  <= 1'b1;
            hblank <= 1'b0;
            x_pos  <= '0;
            y_pos  <= '0;
        end else begin
            hsync  <= hs_act ? HPOL : ~HPOL;
            vsync  <= vs_act ? VPOL : ~VPOL;
            blank  <= hb | vb;
            hblank <= hb;
            x_pos  <= (hb | vb) ? '0 : h;
            y_pos  <= vb ? '0 : v;
        end
    end

    // Zero-latency strobes for downstream row/frame sequencing.
    always_comb begin
        next_row   = pix_en && (h == H_ROW_END);
        next_frame = pix_en && h_wrap && v_wrap;
    end

`ifdef VGA_TIMING_LINE_MATCH_EN
    // Line-match pulse one clock after next_row on the selected line;
    // lines beyond VTOTAL-1 are never reached by v, so they never fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_match <= 1'b0;
        end else begin
            line_match <= pix_en && (h == H_ROW_END) && (v == match_line);
        end
    end
`endif

endmodule
